// File: rtl/dsp48a1_mac_sequencer.sv
`default_nettype none
// ============================================================================
// dsp48a1_mac_sequencer : CE/OPMODE sequencer for a DSP48A1 MAC job
// Revision: 1.0
// ============================================================================
module dsp48a1_mac_sequencer #(
  parameter int         LEN_W       = 8,
  parameter logic [7:0] OPMODE_LOAD = 8'h01,
  parameter logic [7:0] OPMODE_ACC  = 8'h09
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  output logic             busy,
  output logic             len_err,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ce_ab,
  output logic             ce_m,
  output logic             ce_p,
  output logic [7:0]       opmode,
  output logic             dsp_rst,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FEED   = 2'd1,
    S_DRAIN  = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  state_t           r_state;
  logic [LEN_W-1:0] r_cnt;
  logic             r_first;
  logic             r_v0, r_f0, r_v1, r_f1;
  logic             r_len_err;
  logic             r_dsp_rst;

  logic w_abort;
  logic w_accept;

  // Abort masks the handshake so a pair offered in the abort cycle is dropped.
  assign w_abort  = abort && (r_state != S_IDLE);
  assign w_accept = (r_state == S_FEED) && in_valid && !abort;

  assign busy      = (r_state != S_IDLE);
  assign in_ready  = (r_state == S_FEED) && !abort;
  assign ce_ab     = w_accept;
  assign ce_m      = r_v0;
  assign ce_p      = r_v1;
  assign opmode    = (r_v1 && r_f1) ? OPMODE_LOAD : OPMODE_ACC;
  assign out_valid = (r_state == S_RESULT);
  assign len_err   = r_len_err;
  assign dsp_rst   = r_dsp_rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_first   <= 1'b0;
      r_v0      <= 1'b0;
      r_f0      <= 1'b0;
      r_v1      <= 1'b0;
      r_f1      <= 1'b0;
      r_len_err <= 1'b0;
      r_dsp_rst <= 1'b0;
    end else begin
      r_len_err <= 1'b0;
      r_dsp_rst <= 1'b0;
      // Token pipe tracks each accepted pair through the A/B and M registers.
      r_v0 <= w_accept;
      r_f0 <= w_accept && r_first;
      r_v1 <= r_v0;
      r_f1 <= r_f0;
      if (w_abort) begin
        r_state   <= S_IDLE;
        r_cnt     <= '0;
        r_first   <= 1'b0;
        r_v0      <= 1'b0;
        r_f0      <= 1'b0;
        r_v1      <= 1'b0;
        r_f1      <= 1'b0;
        r_dsp_rst <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              if (len == '0) begin
                r_len_err <= 1'b1;
              end else begin
                r_cnt   <= len;
                r_first <= 1'b1;
                r_state <= S_FEED;
              end
            end
          end
          S_FEED: begin
            if (w_accept) begin
              r_cnt   <= r_cnt - 1'b1;
              r_first <= 1'b0;
              if (r_cnt == LEN_W'(1)) r_state <= S_DRAIN;
            end
          end
          S_DRAIN: begin
            if (r_v1 && !r_v0) r_state <= S_RESULT;
          end
          S_RESULT: begin
            if (out_ready) r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dsp48a1_mac_sequencer.sv
`default_nettype none
// ============================================================================
// tb_dsp48a1_mac_sequencer : self-checking bench with a behavioural slice model
// Revision: 1.0
// ============================================================================
module tb_dsp48a1_mac_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, abort, in_valid, out_ready;
  logic [7:0] len;
  logic       busy, len_err, in_ready, ce_ab, ce_m, ce_p, dsp_rst, out_valid;
  logic [7:0] opmode;

  logic signed [17:0] a_in, b_in;
  logic signed [17:0] opa [256];
  logic signed [17:0] opb [256];
  bit pat [7] = '{1, 0, 1, 0, 0, 1, 1};

  int n_cmp = 0;
  int n_err = 0;

  dsp48a1_mac_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .abort    (abort),
    .busy     (busy),
    .len_err  (len_err),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ce_ab    (ce_ab),
    .ce_m     (ce_m),
    .ce_p     (ce_p),
    .opmode   (opmode),
    .dsp_rst  (dsp_rst),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // DSP48A1 slice model (AREG/BREG, MREG, PREG), driven by the sequencer's controls.
  logic               k_ab, k_m, k_p, k_rst;
  logic [7:0]         k_op;
  logic signed [17:0] k_a, k_b;
  logic signed [17:0] sa, sb;
  logic signed [35:0] sm;
  logic signed [47:0] sp;

  always @(negedge clk) begin
    k_ab <= ce_ab; k_m <= ce_m; k_p <= ce_p; k_rst <= dsp_rst;
    k_op <= opmode; k_a <= a_in; k_b <= b_in;
  end

  always @(posedge clk) begin
    if (k_rst) begin
      sa <= '0; sb <= '0; sm <= '0; sp <= '0;
    end else begin
      if (k_ab) begin sa <= k_a; sb <= k_b; end
      if (k_m) sm <= sa * sb;
      if (k_p) sp <= (k_op == 8'h01) ? sm : sp + sm;
    end
  end

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 256; i++) begin
      opa[i] = 18'(int'($urandom_range(4000)) - 2000);
      opb[i] = 18'(int'($urandom_range(4000)) - 2000);
    end
  endtask

  // One job: start in cycle 0, then cycle-by-cycle checks against the
  // expected accept history. vmode 0=full rate, 1=fixed bubble pattern, 2=random.
  task automatic run_job(input int n, input int vmode, input int hold, input int abort_at);
    logic signed [63:0] sum;
    bit hacc[$];
    bit hfst[$];
    int k, tl, rcyc;
    bit valid, ab, ov, ordy, acc, ex_rdy, done;
    start = 1'b1; len = 8'(n); in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_in_ready", in_ready, 0);
    chk("idle_out_valid", out_valid, 0);
    @(posedge clk); #1;
    start = 1'b0;
    if (n == 0) begin
      @(negedge clk);
      chk("len0_len_err", len_err, 1);
      chk("len0_busy", busy, 0);
      chk("len0_ce", {ce_ab, ce_m, ce_p}, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("len0_len_err_once", len_err, 0);
      chk("len0_busy_after", busy, 0);
      @(posedge clk); #1;
      return;
    end
    hacc = '{0, 0}; hfst = '{0, 0};
    sum = 0; k = 0; tl = -1; rcyc = 0; done = 0; ab = 0;
    for (int c = 1; c <= 4 * n + hold + 20; c++) begin
      ov = (tl >= 0) && (c >= tl + 3);
      case (vmode)
        0:       valid = 1'b1;
        1:       valid = (c <= 7) ? pat[c-1] : 1'b1;
        default: valid = ($urandom_range(2) != 0);
      endcase
      ab   = (abort_at >= 0) && (k == abort_at);
      ordy = ov && (rcyc >= hold);
      in_valid = valid; abort = ab; out_ready = ordy;
      a_in = opa[k % 256]; b_in = opb[k % 256];
      @(negedge clk);
      ex_rdy = (k < n) && !ab;
      acc    = ex_rdy && valid;
      chk("busy", busy, 1);
      chk("in_ready", in_ready, ex_rdy);
      chk("ce_ab", ce_ab, acc);
      chk("ce_m", ce_m, hacc[$]);
      chk("ce_p", ce_p, hacc[$-1]);
      chk("opmode", opmode, (hacc[$-1] && hfst[$-1]) ? 8'h01 : 8'h09);
      chk("out_valid", out_valid, ov);
      chk("dsp_rst_idle", dsp_rst, 0);
      chk("len_err_idle", len_err, 0);
      if (ov) chk("result_p", sp, sum);
      hacc.push_back(acc);
      hfst.push_back(acc && (k == 0));
      if (acc) begin
        sum += opa[k] * opb[k];
        k++;
        if (k == n) tl = c;
      end
      if (ov) rcyc++;
      done = ordy;
      @(posedge clk); #1;
      if (ab || done) break;
    end
    chk("job_finished", done || ab, 1);
    in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
    if (ab) begin
      @(negedge clk);
      chk("abort_busy", busy, 0);
      chk("abort_dsp_rst", dsp_rst, 1);
      chk("abort_out_valid", out_valid, 0);
      chk("abort_pipe_clear", {ce_m, ce_p}, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("abort_dsp_rst_once", dsp_rst, 0);
      chk("abort_out_valid_after", out_valid, 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; len = '0; abort = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_ce", {ce_ab, ce_m, ce_p}, 0);
    chk("rst_opmode", opmode, 8'h09);
    chk("rst_pulses", {dsp_rst, len_err}, 0);
    chk("rst_out_valid", out_valid, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      opa[i] = 18'(2 * i + 1);
      opb[i] = 18'(2 * i + 2);
    end
    run_job(4, 0, 0, -1);
    run_job(4, 1, 0, -1);

    opa[0] = -18'sd3; opb[0] = 18'sd5;
    run_job(1, 0, 0, -1);
    run_job(0, 0, 0, -1);

    fill_rand();
    run_job(4, 0, 5, -1);
    opa[0] = 18'sd2; opb[0] = 18'sd2; opa[1] = 18'sd3; opb[1] = 18'sd3;
    run_job(2, 0, 0, -1);

    fill_rand();
    run_job(4, 0, 0, 2);
    run_job(3, 0, 0, -1);

    // Asynchronous reset in the middle of DRAIN, with no clock edge involved.
    start = 1'b1; len = 8'd3;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_ce", {ce_ab, ce_m, ce_p}, 0);
    chk("arst_opmode", opmode, 8'h09);
    chk("arst_pulses", {dsp_rst, len_err}, 0);
    chk("arst_out_valid", out_valid, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    run_job(2, 0, 0, -1);

    for (int j = 0; j < 6; j++) begin
      fill_rand();
      run_job(int'($urandom_range(1, 20)), 2, int'($urandom_range(3)), -1);
    end
    fill_rand();
    run_job(255, 0, 1, -1);
    fill_rand();
    run_job(255, 2, 0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
